// File: rtl/ror_control_sequencer.sv
// Hardwired fetch/execute sequencer for R-format ALU instructions: walks T0..T6
// and drives Moore-style datapath strobes decoded from the state and IR fields.
module ror_control_sequencer #(
  parameter int NREGS = 16,
  parameter int OPW   = 5
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Stop,
  input  logic [31:0]      IR,
  output logic             Run,
  output logic [3:0]       Tstate,
  output logic             PCout,
  output logic             PCin,
  output logic             IncPC,
  output logic             MARin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             ZHighIn,
  output logic             ZLowIn,
  output logic             ZHighout,
  output logic             Zlowout,
  output logic             HIin,
  output logic             LOin,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic [OPW-1:0]   alu_op
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd15
  } state_t;

  state_t state_q, state_d;

  logic [4:0]       opcode;
  logic [3:0]       ra, rb, rc;
  logic             op_valid, op_muldiv, op_halt;
  logic [OPW-1:0]   op_alu;
  logic [NREGS-1:0] onehot_ra, onehot_rb, onehot_rc;
  logic             unused_ir;

  assign opcode    = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];
  assign onehot_ra = NREGS'(1) << ra;
  assign onehot_rb = NREGS'(1) << rb;
  assign onehot_rc = NREGS'(1) << rc;

  always_comb begin
    op_valid  = 1'b1;
    op_muldiv = 1'b0;
    op_halt   = 1'b0;
    op_alu    = '0;
    case (opcode)
      5'b00011: op_alu = OPW'(1);
      5'b00100: op_alu = OPW'(2);
      5'b00101: op_alu = OPW'(3);
      5'b00110: op_alu = OPW'(4);
      5'b00111: op_alu = OPW'(5);
      5'b01000: op_alu = OPW'(6);
      5'b01001: op_alu = OPW'(7);
      5'b01010: op_alu = OPW'(8);
      5'b01111: begin op_alu = OPW'(9);  op_muldiv = 1'b1; end
      5'b10000: begin op_alu = OPW'(10); op_muldiv = 1'b1; end
      5'b11011: begin op_valid = 1'b0; op_halt = 1'b1; end
      default:  op_valid = 1'b0;
    endcase
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Instruction boundaries (T3 nop, T5 non-mul/div, T6) are the only places Stop is honoured.
  always_comb begin
    state_d  = state_q;
    Run      = 1'b0;
    Tstate   = state_q;
    PCout    = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    ZHighIn  = 1'b0;
    ZLowIn   = 1'b0;
    ZHighout = 1'b0;
    Zlowout  = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Rin      = '0;
    Rout     = '0;
    alu_op   = '0;
    case (state_q)
      S_IDLE: if (!Stop) state_d = S_T0;
      S_T0: begin
        Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        state_d = S_T2;
      end
      S_T2: begin
        Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        Run = 1'b1;
        if (op_valid) begin
          Rout = onehot_rb; Yin = 1'b1;
          state_d = S_T4;
        end else if (op_halt) begin
          state_d = S_HALT;
        end else begin
          state_d = Stop ? S_HALT : S_T0;
        end
      end
      S_T4: begin
        Run = 1'b1; Rout = onehot_rc; alu_op = op_alu; ZLowIn = 1'b1;
        ZHighIn = op_muldiv;
        state_d = S_T5;
      end
      S_T5: begin
        Run = 1'b1; Zlowout = 1'b1;
        if (op_muldiv) begin
          LOin = 1'b1;
          state_d = S_T6;
        end else begin
          Rin = onehot_ra;
          state_d = Stop ? S_HALT : S_T0;
        end
      end
      S_T6: begin
        Run = 1'b1; ZHighout = 1'b1; HIin = 1'b1;
        state_d = Stop ? S_HALT : S_T0;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/ror_control_sequencer.md
Name: ror_control_sequencer

Overview:
- Hardwired control unit that generates, cycle by cycle, the datapath control strobes that the CPU datapath consumes: fetch (T0–T2) and execute (T3–T6) for R-format ALU instructions.
- Sits beside the CPU datapath and replaces hand-driven control sequencing.
- Decodes the IR opcode and register fields into one-hot register enables and a 5-bit ALU op.

Parameters:
- NREGS, 16, number of general registers (width of Rin/Rout one-hot buses)
- OPW, 5, width of the opcode field and of alu_op

Ports:
- Clock  in  1  system clock, all state changes on rising edge
- Clear  in  1  asynchronous, active-high reset
- Stop  in  1  request halt at the next instruction boundary
- IR  in  32  instruction register contents from the datapath; valid from T3 onward
- Run  out  1  high while sequencing, low in IDLE/HALT
- Tstate  out  4  current state encoding (debug)
- PCout, PCin, IncPC, MARin  out  1 each  PC/MAR strobes
- Read, MDRin, MDRout, IRin, Yin  out  1 each  memory/MDR/IR/Y strobes
- ZHighIn, ZLowIn, ZHighout, Zlowout  out  1 each  Z register strobes
- HIin, LOin  out  1 each  HI/LO load enables
- Rin  out  NREGS  one-hot register load enable
- Rout  out  NREGS  one-hot register bus drive
- alu_op  out  OPW  ALU operation select

Behaviour:
- IR fields: opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
- Opcode → alu_op:
  - 00011 add → 00001
  - 00100 sub → 00010
  - 00101 and → 00011
  - 00110 or → 00100
  - 00111 shr → 00101
  - 01000 shl → 00110
  - 01001 ror → 00111
  - 01010 rol → 01000
  - 01111 mul → 01001
  - 10000 div → 01010
  - 11011 halt
  - every other opcode is treated as nop.
- Outputs are combinational functions of the state register and IR only (Moore per state).
- Every output not listed for a state is 0.
- Clear high (asynchronous): state = IDLE; all outputs 0, Run = 0, Tstate = 0. Clear dominates all other inputs.
- IDLE → T0 on the first rising edge with Clear low and Stop low. If Stop is high, stay in IDLE.
- T0: PCout, MARin, IncPC, ZLowIn. → T1.
- T1: Zlowout, PCin, Read, MDRin. → T2.
- T2: MDRout, IRin. → T3.
- T3:
  - Valid ALU opcode: Rout = one-hot(Rb), Yin. → T4.
  - halt opcode: no strobes. → HALT.
  - nop/illegal opcode: no strobes. → T0, or HALT if Stop is high.
- T4: Rout = one-hot(Rc), alu_op = decoded value, ZLowIn. mul/div also assert ZHighIn. → T5.
- T5:
  - mul/div: Zlowout, LOin. → T6.
  - Other ops: Zlowout, Rin = one-hot(Ra). → T0, or HALT if Stop is high.
- T6 (mul/div only): ZHighout, HIin. → T0, or HALT if Stop is high.
- HALT: Run = 0, all strobes 0. Exit only via Clear.
- Run = 1 in T0–T6.
- Tstate encoding: IDLE = 0, T0..T6 = 1..7, HALT = 15.
- Rin and Rout are never both nonzero in the same state.
- At most one of {PCout, Zlowout, ZHighout, MDRout, Rout≠0} is asserted in any state (single bus driver).
- Stop is sampled only at instruction boundaries (T3 nop, T5, T6). Stop asserted mid-instruction lets the instruction complete.
- Latency: ALU ops take 6 cycles, T0 to the next T0. mul/div take 7 cycles. nop takes 4 cycles.
- Clear asserted mid-instruction aborts immediately; no strobe persists past the asynchronous reset.

Test Plan:
- Clear high then low, Stop = 0 → IDLE with all outputs 0; one edge later Tstate = 1, PCout = MARin = IncPC = ZLowIn = 1, Run = 1.
- IR = 0x4A920000 (ror R5,R2,R4):
  - T3: Rout = 0x0004, Yin = 1.
  - T4: Rout = 0x0010, alu_op = 00111, ZLowIn = 1.
  - T5: Zlowout = 1, Rin = 0x0020.
  - Next state T0; 6 cycles total.
- IR = 0x78120000 (mul R2,R4):
  - T4: alu_op = 01001, ZHighIn = ZLowIn = 1.
  - T5: Zlowout, LOin, Rin = 0.
  - T6: ZHighout, HIin.
  - Next state T0; 7 cycles total.
- IR = 0xF8000000 (illegal) → T3 has all strobes 0, then T0. IR = 0xD8000000 (halt) → T3 → HALT; Run = 0, Tstate = 15, held for 20 cycles until Clear.
- Stop raised during T4 of an add → T5 completes with Rin written, then HALT. Stop raised during T1 of a nop → HALT after T3.
- Clear pulsed asynchronously mid-T4 (between edges) → all outputs 0 immediately, state IDLE; resumes at T0 after release.
